mac_kbd_link: RTL and testbench

MAC_KBD_LINK -- requirements
Module: mac_kbd_link

---
 rtl/mac_kbd_link.sv | 179 +++++++++++++++++
 tb/tb_mac_kbd_link.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_kbd_link.sv
// Mac Plus keyboard / ADB serial link: drives kbdclk, captures command
// bytes from the Mac and replies from a small response FIFO.
module mac_kbd_link #(
    parameter int                   DATA_BITS  = 8,
    parameter int                   DIV_PLUS   = 1300,
    parameter int                   DIV_ADB    = 80,
    parameter int                   RESP_DEPTH = 4,
    parameter int                   TIMEOUT    = 2000000,
    parameter logic [DATA_BITS-1:0] NULL_BYTE  = 8'h7B
) (
    input  logic                        clk,
    input  logic                        _reset,
    input  logic                        clk_en,
    input  logic                        mode,
    input  logic                        start,
    input  logic                        dat_i,
    output logic                        dat_o,
    output logic                        kbdclk,
    output logic [DATA_BITS-1:0]        cmd_data,
    output logic                        cmd_strobe,
    input  logic [DATA_BITS-1:0]        rsp_data,
    input  logic                        rsp_valid,
    output logic                        rsp_ready,
    input  logic                        flush,
    output logic                        busy,
    output logic [$clog2(RESP_DEPTH):0] level
);

    localparam int DIV_MAX = (DIV_PLUS > DIV_ADB) ? DIV_PLUS : DIV_ADB;
    localparam int DW = $clog2(DIV_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(RESP_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TX      = 2'd1;
    localparam logic [1:0] WAIT_RX = 2'd2;
    localparam logic [1:0] RX      = 2'd3;

    localparam logic [BW-1:0] LAST     = BW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TMO      = TW'(TIMEOUT);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(RESP_DEPTH);

    logic [1:0]           state;
    logic [DW-1:0]        cnt;
    logic [DW-1:0]        div;
    logic [BW-1:0]        bitcnt;
    logic [TW-1:0]        tcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rxbyte;
    logic                 start_q;
    logic                 start_rise;
    logic                 mode_q;

    logic [DATA_BITS-1:0] mem [RESP_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign empty      = (level == '0);
    assign rsp_ready  = (level != FULL_LVL);
    assign push       = rsp_valid && rsp_ready && !flush;
    assign busy       = (state != IDLE);
    assign start_rise = start && !start_q;
    // mode_q is frozen outside IDLE so a mid-byte mode change waits
    assign div = mode_q ? DW'(DIV_ADB) : DW'(DIV_PLUS);

    always_comb begin
        pop = 1'b0;
        if (clk_en && !empty) begin
            if (state == IDLE && mode && !start_rise)
                pop = 1'b1;
            if (state == WAIT_RX && dat_i)
                pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rsp_data;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            kbdclk     <= 1'b1;
            dat_o      <= 1'b1;
            bitcnt     <= '0;
            tcnt       <= '0;
            shreg      <= '0;
            rxbyte     <= '0;
            cmd_data   <= '0;
            cmd_strobe <= 1'b0;
            start_q    <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            if (clk_en) begin
                start_q <= start;
                unique case (1'b1)
                    state == IDLE: begin
                        mode_q <= mode;
                        cnt    <= '0;
                        kbdclk <= 1'b1;
                        if (mode ? start_rise : !dat_i) begin
                            state <= TX;
                        end else if (pop) begin
                            rxbyte <= mem[rd_ptr];
                            state  <= RX;
                        end
                    end
                    state == TX, state == RX: begin
                        if (cnt == div) begin
                            cnt    <= '0;
                            kbdclk <= !kbdclk;
                            if (kbdclk) begin
                                if (state == TX)
                                    shreg <= {shreg[DATA_BITS-2:0], dat_i};
                                else
                                    dat_o <= rxbyte[LAST - bitcnt];
                            end else if (bitcnt == LAST) begin
                                bitcnt <= '0;
                                if (state == TX) begin
                                    cmd_data   <= shreg;
                                    cmd_strobe <= 1'b1;
                                    tcnt       <= '0;
                                    state      <= mode_q ? IDLE : WAIT_RX;
                                end else begin
                                    dat_o <= 1'b1;
                                    state <= IDLE;
                                end
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    state == WAIT_RX: begin
                        if (pop) begin
                            rxbyte <= mem[rd_ptr];
                            state  <= RX;
                        end else if (dat_i && tcnt == TMO) begin
                            rxbyte <= NULL_BYTE;
                            state  <= RX;
                        end
                        if (tcnt != TMO)
                            tcnt <= tcnt + 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_kbd_link.sv
// Scoreboard bench for mac_kbd_link: Plus command/reply, timeout null
// reply, ADB start priority, FIFO fill/flush and mid-byte reset.
module tb_mac_kbd_link;

    localparam int DB  = 8;
    localparam int DVP = 3;
    localparam int DVA = 1;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          _reset = 1'b0;
    logic          mode = 1'b0;
    logic          start = 1'b0;
    logic          dat_i = 1'b1;
    logic          dat_o;
    logic          kbdclk;
    logic [DB-1:0] cmd_data;
    logic          cmd_strobe;
    logic [DB-1:0] rsp_data = '0;
    logic          rsp_valid = 1'b0;
    logic          rsp_ready;
    logic          flush = 1'b0;
    logic          busy;
    logic [2:0]    level;

    int            n_vec = 0;
    int            n_err = 0;
    int            strobes = 0;
    logic [7:0]    cmd_q[$];
    logic [7:0]    rsp_q[$];
    longint        fall_t[$];

    mac_kbd_link #(
        .DATA_BITS(DB), .DIV_PLUS(DVP), .DIV_ADB(DVA),
        .RESP_DEPTH(4), .TIMEOUT(TMO), .NULL_BYTE(8'h7B)
    ) dut (
        .clk(clk), ._reset(_reset), .clk_en(clk_en), .mode(mode),
        .start(start), .dat_i(dat_i), .dat_o(dat_o), .kbdclk(kbdclk),
        .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .flush(flush), .busy(busy),
        .level(level)
    );

    always #5 clk = !clk;
    always @(negedge clk) clk_en = !clk_en;
    always @(negedge kbdclk) fall_t.push_back($time);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_strobe === 1'b1) begin
            strobes++;
            check("cmd_q_nonempty", 32'(cmd_q.size() != 0), 1);
            if (cmd_q.size() != 0)
                check("cmd_data", cmd_data, cmd_q.pop_front());
        end
    end

    task automatic wait_kbd(input logic v, input string tag);
        int n = 0;
        while (kbdclk !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (kbdclk !== v)
            check(tag, kbdclk, v);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b1)
            check(tag, busy, 1);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = DB - 1; i >= 0; i--) begin
            dat_i = b[i];
            wait_kbd(1'b0, "tx_fall_tmo");
            dat_i = 1'b0;
            wait_kbd(1'b1, "tx_rise_tmo");
        end
    endtask

    task automatic recv_byte(input string tag);
        logic [7:0] got;
        got = '0;
        for (int i = DB - 1; i >= 0; i--) begin
            wait_kbd(1'b0, "rx_fall_tmo");
            got[i] = dat_o;
            wait_kbd(1'b1, "rx_rise_tmo");
        end
        check({tag, "_q"}, 32'(rsp_q.size() != 0), 1);
        if (rsp_q.size() != 0)
            check(tag, got, rsp_q.pop_front());
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_dat_o"}, dat_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        repeat (3) @(negedge clk);
        check("rst_kbdclk", kbdclk, 1);
        check("rst_dat_o", dat_o, 1);
        check("rst_busy", busy, 0);
        check("rst_cmd", cmd_data, 0);
        check("rst_level", level, 0);
        _reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_ready", rsp_ready, 1);

        // fill past depth, then flush while still pushing
        rsp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rsp_data = 8'h40 + 8'(i);
            @(negedge clk);
            check("fill_level", level, (i < 4) ? i + 1 : 4);
            check("fill_ready", rsp_ready, (i < 3) ? 1 : 0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rsp_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_ready", rsp_ready, 1);

        // Plus command A5 with preloaded reply 3C
        rsp_data = 8'h3C;
        rsp_valid = 1'b1;
        rsp_q.push_back(8'h3C);
        @(negedge clk);
        rsp_valid = 1'b0;
        check("preload_level", level, 1);
        cmd_q.push_back(8'hA5);
        s0 = strobes;
        fall_t.delete();
        dat_i = 1'b0;
        wait_busy("plus_tx_start");
        send_bits(8'hA5);
        repeat (4) @(negedge clk);
        check("plus_strobes", strobes - s0, 1);
        check("plus_falls", fall_t.size(), 8);
        for (int i = 1; i < fall_t.size(); i++)
            check("plus_period", 32'(fall_t[i] - fall_t[i-1]),
                  32'(2 * 2 * (DVP + 1) * 10));
        check("wait_busy", busy, 1);
        check("wait_kbdclk", kbdclk, 1);
        check("wait_level", level, 1);
        dat_i = 1'b1;
        recv_byte("plus_rsp");
        check("plus_level", level, 0);

        // empty FIFO: null reply after timeout
        cmd_q.push_back(8'h96);
        dat_i = 1'b0;
        wait_busy("tmo_tx_start");
        send_bits(8'h96);
        dat_i = 1'b1;
        rsp_q.push_back(8'h7B);
        n = 0;
        while (kbdclk === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tmo_lat", 32'(n >= 2 * (TMO + DVP + 1) &&
                             n <= 2 * (TMO + DVP + 2)), 1);
        recv_byte("null_rsp");

        // ADB: start edge in the cycle the FIFO fills wins
        mode = 1'b1;
        repeat (2) @(negedge clk);
        cmd_q.push_back(8'h2C);
        rsp_q.push_back(8'h11);
        s0 = strobes;
        rsp_data = 8'h11;
        rsp_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        @(negedge clk);
        check("adb_busy", busy, 1);
        check("adb_level_hold", level, 1);
        fall_t.delete();
        send_bits(8'h2C);
        check("adb_period", 32'(fall_t[1] - fall_t[0]),
              32'(2 * 2 * (DVA + 1) * 10));
        recv_byte("adb_rsp");
        check("adb_strobes", strobes - s0, 1);
        check("adb_level", level, 0);

        // reset in the middle of bit 3 of a Plus command
        start = 1'b0;
        mode = 1'b0;
        dat_i = 1'b1;
        repeat (4) @(negedge clk);
        s0 = strobes;
        dat_i = 1'b0;
        wait_busy("rst_tx_start");
        for (int i = 0; i < 3; i++) begin
            dat_i = 1'b1;
            wait_kbd(1'b0, "rst_fall_tmo");
            wait_kbd(1'b1, "rst_rise_tmo");
        end
        wait_kbd(1'b0, "rst_bit3_tmo");
        #2 _reset = 1'b0;
        #1;
        check("mid_rst_kbdclk", kbdclk, 1);
        check("mid_rst_dat_o", dat_o, 1);
        check("mid_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        dat_i = 1'b1;
        _reset = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_rst_strobes", strobes - s0, 0);
        check("mid_rst_cmd", cmd_data, 0);
        check("mid_rst_idle", busy, 0);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
